apb_gpio_irq: RTL

Parametrised APB3 GPIO peripheral; successor to the fixed 4-bit GPO on the MCU bus.
- Per-pin direction control, output data register, synchronised input sampling.
- Per-pin edge-triggered interrupt with selectable polarity and W1C status.
- Sits on the APB bridge alongside UART; `irq` routes to the CPU interrupt input.

---
 rtl/gpio_pkg.sv | 21 ++
 rtl/gpio_sync_edge.sv | 42 ++++
 rtl/apb_gpio_irq.sv | 114 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO block: register offsets and edge polarity.
package gpio_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    // Byte offsets of the register map (PADDR[1:0] is never decoded)
    localparam logic [ADDR_W-1:0] DIR_OFS  = 5'h00;
    localparam logic [ADDR_W-1:0] ODR_OFS  = 5'h04;
    localparam logic [ADDR_W-1:0] IDR_OFS  = 5'h08;
    localparam logic [ADDR_W-1:0] IER_OFS  = 5'h0C;
    localparam logic [ADDR_W-1:0] EDGE_OFS = 5'h10;
    localparam logic [ADDR_W-1:0] ISR_OFS  = 5'h14;

    // Per-pin interrupt polarity held in the EDGE register
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_pol_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser plus one-cycle history for edge detection.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   gpio_in      : asynchronous pad inputs
//   sync         : synchronised pin values (last synchroniser stage)
//   rise, fall   : per-pin edges of sync relative to its previous cycle
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Synchroniser chain; prev_q holds sync from the previous cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= gpio_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[SYNC_STAGES-1];
        end
    end

    assign sync = stage_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO peripheral with per-pin direction, output data, synchronised
// input readback and edge-triggered interrupts (W1C status, level irq).
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA : APB3 request, zero wait states
//   PRDATA, PREADY                : APB3 response (combinational)
//   gpio_in                       : asynchronous pad inputs
//   gpio_out, gpio_oe             : registered pad data and output enables
//   irq                           : registered interrupt request, active-high
module apb_gpio_irq
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    logic [WIDTH-1:0]  dir_q, odr_q, ier_q, edge_q, isr_q;
    logic [WIDTH-1:0]  sync_q, rise_c, fall_c, evt_c, w1c_c, wdata_c;
    logic              access_c, wr_c, rd_c;
    logic [ADDR_W-1:0] ofs_c;
    logic              unused_bits;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .gpio_in (gpio_in),
        .sync    (sync_q),
        .rise    (rise_c),
        .fall    (fall_c)
    );

    // APB decode; byte lane bits are dropped so any alignment hits the word
    assign access_c = PSEL & PENABLE;
    assign wr_c     = access_c & PWRITE;
    assign rd_c     = access_c & ~PWRITE;
    assign ofs_c    = {PADDR[4:2], 2'b00};
    assign wdata_c  = PWDATA[WIDTH-1:0];
    assign PREADY   = access_c;

    // Bits outside the pin range and the byte lane never affect state
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    // Per-pin event selection by configured polarity
    always_comb begin
        evt_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            evt_c[i] = (edge_pol_e'(edge_q[i]) == EDGE_FALL) ? fall_c[i] : rise_c[i];
        end
    end

    assign w1c_c = (wr_c && ofs_c == ISR_OFS) ? wdata_c : '0;

    // Registers, status and pin outputs; a new event outranks a W1C
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q    <= '0;
            odr_q    <= '0;
            ier_q    <= '0;
            edge_q   <= '0;
            isr_q    <= '0;
            irq      <= 1'b0;
            gpio_out <= '0;
            gpio_oe  <= '0;
        end else begin
            if (wr_c) begin
                case (ofs_c)
                    DIR_OFS:  dir_q  <= wdata_c;
                    ODR_OFS:  odr_q  <= wdata_c;
                    IER_OFS:  ier_q  <= wdata_c;
                    EDGE_OFS: edge_q <= wdata_c;
                    default:  ;
                endcase
            end
            isr_q    <= (isr_q & ~w1c_c) | evt_c;
            irq      <= |(isr_q & ier_q);
            gpio_out <= odr_q;
            gpio_oe  <= dir_q;
        end
    end

    // Read mux, driven only during a read access phase
    always_comb begin
        PRDATA = '0;
        if (rd_c) begin
            case (ofs_c)
                DIR_OFS:  PRDATA = DATA_W'(dir_q);
                ODR_OFS:  PRDATA = DATA_W'(odr_q);
                IDR_OFS:  PRDATA = DATA_W'(sync_q);
                IER_OFS:  PRDATA = DATA_W'(ier_q);
                EDGE_OFS: PRDATA = DATA_W'(edge_q);
                ISR_OFS:  PRDATA = DATA_W'(isr_q);
                default:  PRDATA = '0;
            endcase
        end
    end

endmodule
